// File: rtl/stepper_move_ctrl.sv
// Four-phase unipolar stepper move controller: accepts move commands, steps the
// coils with a linear accel/decel ramp and tracks absolute signed position.
module stepper_move_ctrl #(
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned POS_W     = 24,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned START_DIV = 2000,
    parameter int unsigned MIN_DIV   = 200,
    parameter int unsigned ACCEL_DEC = 50,
    parameter bit          HOLD_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [1:0]        cmd_mode,
    input  logic              enable,
    input  logic              abort,
    output logic [3:0]        coil,
    output logic              step_pulse,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    localparam int unsigned      EXT_W   = DIV_W + 2;
    localparam logic [DIV_W-1:0] START_P = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ACC_P   = DIV_W'(ACCEL_DEC);
    localparam logic [EXT_W-1:0] START_X = EXT_W'(START_DIV);
    localparam logic [EXT_W-1:0] MIN_X   = EXT_W'(MIN_DIV);
    localparam logic [EXT_W-1:0] ACC_X   = EXT_W'(ACCEL_DEC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              dir;
    logic [1:0]        mode;
    logic [STEP_W-1:0] steps;
    logic [STEP_W-1:0] taken;
    logic [STEP_W-1:0] ramp;
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  timer;
    logic [2:0]        idx;

    logic [2:0]        idx_align_c;
    logic [2:0]        idx_step_c;
    logic              step_due_c;
    logic [STEP_W-1:0] taken_inc_c;
    logic [STEP_W-1:0] remaining_c;
    logic [EXT_W-1:0]  period_x_c;
    logic [DIV_W-1:0]  period_slow_c;
    logic [DIV_W-1:0]  period_fast_c;

    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b1000;
            3'd1:    phase = 4'b1100;
            3'd2:    phase = 4'b0100;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0010;
            3'd5:    phase = 4'b0011;
            3'd6:    phase = 4'b0001;
            default: phase = 4'b1001;
        endcase
    endfunction

    // Phase alignment, next phase, and saturating ramp arithmetic
    always_comb begin
        case (cmd_mode)
            2'd0:    idx_align_c = {idx[2:1], 1'b0};
            2'd2:    idx_align_c = idx;
            default: idx_align_c = {idx[2:1], 1'b1};
        endcase
        if (mode == 2'd2) begin
            idx_step_c = dir ? idx + 3'd1 : idx - 3'd1;
        end else begin
            idx_step_c = dir ? idx + 3'd2 : idx - 3'd2;
        end
        step_due_c    = (timer == period - DIV_W'(1));
        taken_inc_c   = taken + STEP_W'(1);
        remaining_c   = steps - taken_inc_c;
        period_x_c    = EXT_W'(period);
        period_slow_c = (period_x_c + ACC_X > START_X) ? START_P : period + ACC_P;
        period_fast_c = (period_x_c > MIN_X + ACC_X) ? period - ACC_P : MIN_P;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
            position   <= '0;
            idx        <= '0;
            coil       <= 4'b0000;
            dir        <= 1'b0;
            mode       <= 2'd0;
            steps      <= '0;
            taken      <= '0;
            ramp       <= '0;
            period     <= START_P;
            timer      <= '0;
        end else begin
            done       <= 1'b0;
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir    <= cmd_dir;
                        steps  <= cmd_steps;
                        mode   <= cmd_mode;
                        idx    <= idx_align_c;
                        period <= START_P;
                        timer  <= '0;
                        taken  <= '0;
                        ramp   <= '0;
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                            coil <= HOLD_EN ? phase(idx_align_c) : 4'b0000;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            coil      <= phase(idx_align_c);
                        end
                    end
                end
                RUN: begin
                    if (abort || taken == steps) begin
                        // Abort discards any step due this cycle
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        coil      <= HOLD_EN ? phase(idx) : 4'b0000;
                    end else if (enable) begin
                        if (step_due_c) begin
                            timer      <= '0;
                            idx        <= idx_step_c;
                            coil       <= phase(idx_step_c);
                            step_pulse <= 1'b1;
                            taken      <= taken_inc_c;
                            position   <= dir ? position + POS_W'(1) : position - POS_W'(1);
                            if (remaining_c <= ramp) begin
                                period <= period_slow_c;
                                ramp   <= (ramp == '0) ? '0 : ramp - STEP_W'(1);
                            end else if (period > MIN_P) begin
                                period <= period_fast_c;
                                ramp   <= ramp + STEP_W'(1);
                            end
                        end else begin
                            timer <= timer + DIV_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl: a fast no-ramp instance for phase/timing
// scenarios and a default-parameter instance for the acceleration ramp.
module tb_stepper_move_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid_f = 1'b0;
    logic        cmd_valid_d = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [1:0]  cmd_mode = 2'd0;
    logic        enable = 1'b1;
    logic        abort = 1'b0;

    logic        rdy_f, sp_f, busy_f, done_f;
    logic [3:0]  coil_f;
    logic [23:0] pos_f;
    logic        rdy_d, sp_d, busy_d, done_d;
    logic [3:0]  coil_d;
    logic [23:0] pos_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stepper_move_ctrl #(.START_DIV(10), .MIN_DIV(10)) dut_f (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_f), .cmd_ready(rdy_f),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_mode(cmd_mode),
        .enable(enable), .abort(abort), .coil(coil_f), .step_pulse(sp_f),
        .busy(busy_f), .done(done_f), .position(pos_f)
    );

    stepper_move_ctrl dut_d (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_d), .cmd_ready(rdy_d),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_mode(cmd_mode),
        .enable(enable), .abort(abort), .coil(coil_d), .step_pulse(sp_d),
        .busy(busy_d), .done(done_d), .position(pos_d)
    );

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Present one command for a single clock; returns #1 after the accepting edge
    task automatic issue(input bit fast, input logic d, input logic [15:0] n, input logic [1:0] m);
        cmd_dir = d;
        cmd_steps = n;
        cmd_mode = m;
        if (fast) cmd_valid_f = 1'b1; else cmd_valid_d = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_f = 1'b0;
        cmd_valid_d = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        apply_reset();
        checks++;
        if (coil_f !== 4'b0000 || pos_f !== 24'd0 || rdy_f !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_fast: coil=%b pos=%0d rdy=%b busy=%b done=%b, required 0000 0 1 0 0",
                     coil_f, pos_f, rdy_f, busy_f, done_f);
        end
        checks++;
        if (coil_d !== 4'b0000 || pos_d !== 24'd0 || rdy_d !== 1'b1 || busy_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_default: coil=%b pos=%0d rdy=%b busy=%b, required 0000 0 1 0",
                     coil_d, pos_d, rdy_d, busy_d);
        end
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (sp_f || sp_d) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_idle_pulses: got %0d step pulses, required 0", pulses);
        end
    endtask

    task automatic test_full_mode();
        logic [3:0] exp_c [0:3];
        int pulses;
        exp_c[0] = 4'b0110; exp_c[1] = 4'b0011; exp_c[2] = 4'b1001; exp_c[3] = 4'b1100;
        issue(1'b1, 1'b1, 16'd4, 2'd1);
        checks++;
        if (coil_f !== 4'b1100 || busy_f !== 1'b1 || rdy_f !== 1'b0 || sp_f !== 1'b0) begin
            errors++;
            $display("FAIL full_align: coil=%b busy=%b rdy=%b sp=%b, required 1100 1 0 0", coil_f, busy_f, rdy_f, sp_f);
        end
        pulses = 0;
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            if (sp_f) begin
                checks++;
                if (pulses >= 4 || k != 10 * (pulses + 1) || coil_f !== exp_c[pulses[1:0]]) begin
                    errors++;
                    $display("FAIL full_step%0d: cycle %0d coil %b, required cycle %0d coil %b",
                             pulses, k, coil_f, 10 * (pulses + 1), exp_c[pulses[1:0]]);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 4 || done_f !== 1'b1 || rdy_f !== 1'b1 || busy_f !== 1'b0 || pos_f !== 24'd4) begin
            errors++;
            $display("FAIL full_end: pulses=%0d done=%b rdy=%b busy=%b pos=%0d, required 4 1 1 0 4",
                     pulses, done_f, rdy_f, busy_f, pos_f);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_f !== 1'b0 || coil_f !== 4'b1100) begin
            errors++;
            $display("FAIL full_hold: done=%b coil=%b, required 0 1100", done_f, coil_f);
        end
    endtask

    task automatic test_half_wave();
        logic [3:0] exp_h [0:2];
        logic [3:0] exp_w [0:1];
        int pulses;
        exp_h[0] = 4'b1001; exp_h[1] = 4'b0001; exp_h[2] = 4'b0011;
        exp_w[0] = 4'b0001; exp_w[1] = 4'b1000;
        apply_reset();
        issue(1'b1, 1'b0, 16'd3, 2'd2);
        pulses = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            if (sp_f) begin
                checks++;
                if (pulses >= 3 || k != 10 * (pulses + 1) || coil_f !== exp_h[pulses]) begin
                    errors++;
                    $display("FAIL half_step%0d: cycle %0d coil %b", pulses, k, coil_f);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 3 || done_f !== 1'b1 || pos_f !== 24'hFFFFFD) begin
            errors++;
            $display("FAIL half_end: pulses=%0d done=%b pos=%0d, required 3 1 -3", pulses, done_f, $signed(pos_f));
        end
        issue(1'b1, 1'b1, 16'd2, 2'd0);
        checks++;
        if (coil_f !== 4'b0010 || sp_f !== 1'b0 || pos_f !== 24'hFFFFFD) begin
            errors++;
            $display("FAIL wave_align: coil=%b sp=%b pos=%0d, required 0010 0 -3", coil_f, sp_f, $signed(pos_f));
        end
        pulses = 0;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            if (sp_f) begin
                checks++;
                if (pulses >= 2 || k != 10 * (pulses + 1) || coil_f !== exp_w[pulses]) begin
                    errors++;
                    $display("FAIL wave_step%0d: cycle %0d coil %b", pulses, k, coil_f);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 2 || done_f !== 1'b1 || pos_f !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL wave_end: pulses=%0d done=%b pos=%0d, required 2 1 -1", pulses, done_f, $signed(pos_f));
        end
    endtask

    // Intervals: 2000 down by 50 to 1500 at step 11, then up by 50 per step
    task automatic test_ramp();
        int last;
        int n;
        int expv;
        int k;
        issue(1'b0, 1'b1, 16'd20, 2'd1);
        last = 0;
        n = 0;
        k = 0;
        while (k < 40000 && !done_d) begin
            @(posedge clk);
            #1;
            k++;
            if (sp_d) begin
                n++;
                expv = (n <= 11) ? 2000 - 50 * (n - 1) : 1500 + 50 * (n - 11);
                checks++;
                if (k - last != expv) begin
                    errors++;
                    $display("FAIL ramp_interval%0d: got %0d cycles, required %0d", n, k - last, expv);
                end
                last = k;
            end
        end
        checks++;
        if (done_d !== 1'b1 || n != 20 || pos_d !== 24'd20 || rdy_d !== 1'b1) begin
            errors++;
            $display("FAIL ramp_end: done=%b steps=%0d pos=%0d rdy=%b, required 1 20 20 1", done_d, n, pos_d, rdy_d);
        end
    endtask

    task automatic test_pause();
        int exp_t [0:5];
        int pulses;
        int moved;
        logic [3:0] held;
        exp_t[0] = 10; exp_t[1] = 20; exp_t[2] = 30; exp_t[3] = 540; exp_t[4] = 550; exp_t[5] = 560;
        issue(1'b1, 1'b1, 16'd6, 2'd1);
        pulses = 0;
        moved = 0;
        held = 4'b0000;
        for (int k = 1; k <= 561; k++) begin
            @(posedge clk);
            #1;
            if (k == 33) held = coil_f;
            if (k > 33 && k <= 533 && (sp_f || coil_f !== held || busy_f !== 1'b1)) moved++;
            enable = (k >= 33 && k < 533) ? 1'b0 : 1'b1;
            if (sp_f) begin
                checks++;
                if (pulses >= 6 || k != exp_t[pulses]) begin
                    errors++;
                    $display("FAIL pause_step%0d: cycle %0d, required %0d", pulses, k, pulses < 6 ? exp_t[pulses] : -1);
                end
                pulses++;
            end
        end
        enable = 1'b1;
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL pause_frozen: %0d cycles with activity while paused, required 0", moved);
        end
        checks++;
        if (pulses != 6 || done_f !== 1'b1 || pos_f !== 24'd5) begin
            errors++;
            $display("FAIL pause_end: pulses=%0d done=%b pos=%0d, required 6 1 5", pulses, done_f, pos_f);
        end
    endtask

    task automatic test_abort_zero();
        int pulses;
        int early;
        issue(1'b1, 1'b1, 16'd50, 2'd1);
        pulses = 0;
        early = 0;
        for (int k = 1; k <= 76; k++) begin
            @(posedge clk);
            #1;
            if (sp_f) pulses++;
            if (k < 76 && done_f) early++;
            abort = (k == 75) ? 1'b1 : 1'b0;
        end
        abort = 1'b0;
        checks++;
        if (done_f !== 1'b1 || early != 0 || pulses != 7 || pos_f !== 24'd12 || rdy_f !== 1'b1 || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: done=%b early=%0d pulses=%0d pos=%0d rdy=%b busy=%b, required 1 0 7 12 1 0",
                     done_f, early, pulses, pos_f, rdy_f, busy_f);
        end
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checks++;
        if (rdy_f !== 1'b1 || done_f !== 1'b0 || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: rdy=%b done=%b busy=%b, required 1 0 0", rdy_f, done_f, busy_f);
        end
        issue(1'b1, 1'b1, 16'd0, 2'd1);
        checks++;
        if (done_f !== 1'b1 || busy_f !== 1'b0 || rdy_f !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b rdy=%b, required 1 0 1", done_f, busy_f, rdy_f);
        end
        pulses = 0;
        early = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (sp_f) pulses++;
            if (done_f) early++;
        end
        checks++;
        if (pulses != 0 || early != 0 || pos_f !== 24'd12) begin
            errors++;
            $display("FAIL zero_quiet: pulses=%0d extra_done=%0d pos=%0d, required 0 0 12", pulses, early, pos_f);
        end
    endtask

    initial begin
        test_reset();
        test_full_mode();
        test_half_wave();
        test_ramp();
        test_pause();
        test_abort_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
